// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared types and constants for the 4-input mux arbiter
package mux_pkg;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Next index in round-robin order; the 2-bit width makes 3 wrap to 0.
  function automatic logic [SRC_W-1:0] next_idx(input logic [SRC_W-1:0] idx);
    return idx + SRC_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotate-priority picker over four requests
module rr_pick4
  import mux_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SRC_W-1:0]   ptr,
  output logic [SRC_W-1:0]   idx,
  output logic               any
);

  // Scan from lowest to highest priority so the entry nearest ptr wins last.
  always_comb begin
    idx = ptr;
    any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[ptr + SRC_W'(k)]) begin
        idx = ptr + SRC_W'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_mux4_arb.sv
// rtl/rr_mux4_arb.sv - round-robin 4:1 arbiter with packet lock and registered output
module rr_mux4_arb
  import mux_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        in_valid,
  input  logic [NUM_REQ*DATA_W-1:0] in_data,
  input  logic [NUM_REQ-1:0]        in_last,
  output logic [NUM_REQ-1:0]        in_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [SRC_W-1:0]          out_src,
  input  logic                      out_ready
);

  arb_state_t        state_q, state_d;
  logic [SRC_W-1:0]  ptr_q, ptr_d;
  logic [SRC_W-1:0]  owner_q, owner_d;

  logic [SRC_W-1:0]  pick_idx;
  logic              pick_any;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_vld;
  logic              space;
  logic              in_xfer;
  logic              sel_last;
  logic [DATA_W-1:0] sel_data;

  rr_pick4 u_pick (
    .req (in_valid),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Gating with !rst keeps every in_ready low while reset is held.
  assign space   = !rst && (!out_valid || out_ready);
  assign in_xfer = |(in_valid & in_ready);

  // Grant selection: the owner is the only candidate while a packet is open.
  always_comb begin
    grant_idx = pick_idx;
    grant_vld = pick_any;
    in_ready  = '0;
    if (state_q == LOCK) begin
      grant_idx = owner_q;
      grant_vld = 1'b1;
    end
    if (grant_vld && space) begin
      in_ready[grant_idx] = 1'b1;
    end
  end

  // Payload and last flag of the granted requester.
  always_comb begin
    sel_data = '0;
    sel_last = in_last[grant_idx];
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        sel_data = in_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state logic: a non-last beat opens a lock, a last beat rotates ptr.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    if (in_xfer) begin
      if (sel_last) begin
        state_d = ARB;
        ptr_d   = next_idx(grant_idx);
      end else begin
        state_d = LOCK;
        owner_d = grant_idx;
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Output register: load on accept, otherwise release the beat on drain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_src   <= '0;
    end else if (in_xfer) begin
      out_valid <= 1'b1;
      out_data  <= sel_data;
      out_last  <= sel_last;
      out_src   <= grant_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rr_mux4_arb.sv
// tb/tb_rr_mux4_arb.sv - self-checking bench for rr_mux4_arb
module tb_rr_mux4_arb;

  localparam int DATA_W = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [3:0]          in_valid;
  logic [4*DATA_W-1:0] in_data;
  logic [3:0]          in_last;
  logic [3:0]          in_ready;
  logic                out_valid;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [1:0]          out_src;
  logic                out_ready;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  int          m_lock, m_owner, m_ptr, m_os;
  logic        m_ov, m_ol;
  logic [7:0]  m_od;
  int          n_acc, n_out;

  int          rem [4];
  logic [3:0]  acc;
  int          fair_exp [6] = '{0, 1, 2, 3, 0, 1};

  rr_mux4_arb #(.DATA_W(DATA_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [7:0] d, input logic l);
    in_valid[i]               = 1'b1;
    in_data[i*DATA_W +: DATA_W] = d;
    in_last[i]                = l;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) rem[i] = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Reference model and per-cycle comparison, evaluated mid-cycle.
  always @(negedge clk) begin
    int         g;
    logic       sp;
    logic [3:0] exp_rdy;
    if (rst) begin
      m_lock = 0; m_owner = 0; m_ptr = 0; m_os = 0;
      m_ov = 1'b0; m_ol = 1'b0; m_od = '0;
      n_acc = 0; n_out = 0;
    end else begin
      sp = !m_ov || out_ready;
      g  = -1;
      if (m_lock != 0) g = m_owner;
      else begin
        for (int k = 0; k < 4; k++)
          if (g < 0 && in_valid[(m_ptr + k) % 4]) g = (m_ptr + k) % 4;
      end
      exp_rdy = (g >= 0 && sp) ? 4'(1 << g) : 4'b0000;
      check("in_ready",  32'(in_ready),  32'(exp_rdy));
      check("out_valid", 32'(out_valid), 32'(m_ov));
      check("out_data",  32'(out_data),  32'(m_od));
      check("out_last",  32'(out_last),  32'(m_ol));
      check("out_src",   32'(out_src),   32'(m_os));
      n_acc += $countones(in_valid & in_ready);
      n_out += int'(out_valid & out_ready);
      if (g >= 0 && sp && in_valid[g]) begin
        m_ov = 1'b1;
        m_od = in_data[g*DATA_W +: DATA_W];
        m_ol = in_last[g];
        m_os = g;
        if (in_last[g]) begin
          m_lock = 0;
          m_ptr  = (g + 1) % 4;
        end else begin
          m_lock  = 1;
          m_owner = g;
        end
      end else if (m_ov && out_ready) begin
        m_ov = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = '0; in_data = '0; in_last = '0; out_ready = 1'b1;
    do_reset();

    // asynchronous reset while a beat is held
    out_ready = 1'b0;
    set_src(2, 8'h3C, 1'b0);
    tick();
    check("rst_pre_valid", 32'(out_valid), 32'd1);
    check("rst_pre_src",   32'(out_src),   32'd2);
    #2 rst = 1'b1;
    #1;
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_data",     32'(out_data),  32'd0);
    check("rst_src",      32'(out_src),   32'd0);
    check("rst_in_ready", 32'(in_ready),  32'd0);
    in_valid = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // fairness: everyone valid with single-beat packets
    for (int i = 0; i < 4; i++) set_src(i, 8'h10 + 8'(i), 1'b1);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("fair_src",  32'(out_src),  32'(fair_exp[k]));
      check("fair_data", 32'(out_data), 32'(8'h10 + 8'(fair_exp[k])));
    end
    in_valid = '0;
    tick();

    // packet lock: src1 sends 3 beats while the others wait
    do_reset();
    set_src(0, 8'h01, 1'b1);
    tick();
    in_valid = '0;
    set_src(0, 8'h02, 1'b1);
    set_src(2, 8'h22, 1'b1);
    set_src(3, 8'h33, 1'b1);
    set_src(1, 8'h20, 1'b0);
    for (int b = 0; b < 3; b++) begin
      tick();
      check("lock_src",  32'(out_src),  32'd1);
      check("lock_data", 32'(out_data), 32'(8'h20 + 8'(b)));
      if (b < 2) set_src(1, 8'h21 + 8'(b), b == 1);
      else in_valid[1] = 1'b0;
    end
    tick();
    check("lock_after_src", 32'(out_src), 32'd2);
    in_valid = '0;
    tick();

    // sparse request from src3, then the scan must restart at 0
    do_reset();
    set_src(3, 8'hA5, 1'b1);
    tick();
    check("sparse_data", 32'(out_data), 32'hA5);
    check("sparse_src",  32'(out_src),  32'd3);
    in_valid = '0;
    set_src(1, 8'h11, 1'b1);
    set_src(3, 8'h5A, 1'b1);
    #1;
    check("wrap_ready", 32'(in_ready), 32'b0010);
    tick();
    check("wrap_src", 32'(out_src), 32'd1);
    in_valid[1] = 1'b0;
    tick();
    check("wrap_src3", 32'(out_src), 32'd3);
    in_valid = '0;

    // backpressure with a held beat
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) set_src(i, 8'h60 + 8'(i), 1'b1);
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_ready", 32'(in_ready), 32'd0);
      tick();
      check("bp_data",  32'(out_data),  32'h5A);
      check("bp_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    repeat (8) tick();
    in_valid = '0;
    tick(); tick();
    check("bp_count", 32'(n_acc), 32'(n_out + int'(out_valid)));

    // owner gap inside a locked packet
    do_reset();
    set_src(0, 8'h40, 1'b0);
    set_src(1, 8'h51, 1'b1);
    set_src(2, 8'h52, 1'b1);
    set_src(3, 8'h53, 1'b1);
    tick();
    check("gap_first_src", 32'(out_src), 32'd0);
    in_valid[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      check("gap_others", 32'(in_ready & 4'b1110), 32'd0);
      tick();
    end
    set_src(0, 8'h41, 1'b1);
    tick();
    check("gap_last_src",  32'(out_src),  32'd0);
    check("gap_last_data", 32'(out_data), 32'h41);
    in_valid[0] = 1'b0;
    #1;
    check("gap_next_ready", 32'(in_ready), 32'b0010);
    in_valid = '0;
    tick();

    // randomized traffic against the model
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      #1;
      acc = in_valid & in_ready;
      tick();
      out_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) in_valid[i] = 1'b0;
        if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
          if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
          set_src(i, 8'($urandom), rem[i] == 1);
          rem[i]--;
        end
      end
    end
    in_valid  = '0;
    out_ready = 1'b1;
    tick(); tick(); tick();
    check("rand_count", 32'(n_acc), 32'(n_out + int'(out_valid)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
